// File: rtl/display_pkg.sv
// display_pkg
// Shared types, constants and helper functions for the signed result display.
//   state_t     : conversion FSM states (IDLE, LOAD, SHIFT, DONE)
//   SEG_DIGIT   : active-low 7-segment patterns for 0-9, bit0=a .. bit6=g
//   SEG_BLANK   : all segments off
//   SEG_DASH    : only segment g lit, used for the overflow indication
//   seg_decode  : nibble to active-low segment pattern (10-15 decode to blank)
//   bcd_adjust  : double-dabble add-3 correction applied to every BCD nibble
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BCD_DIGITS  = 5;
  localparam int DISP_DIGITS = 4;
  localparam int DISP_MAX    = 9999;
  localparam int BCD_W       = 4 * BCD_DIGITS;
  localparam int DISP_W      = 4 * DISP_DIGITS;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential double-dabble converter: one add-3/shift step per clock.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   start      : one-cycle strobe; loads bin, clears the accumulator and counter
//   bin        : unsigned binary value sampled on start
//   bcd        : BCD accumulator (BCD_DIGITS nibbles, units in [3:0])
//   done       : high during the last shift cycle; bcd is final the next cycle
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj_s;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;

  // Next-state of the shift datapath: load on start, otherwise step while active.
  always_comb begin
    bcd_d     = bcd_q;
    mag_d     = mag_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    bcd_adj_s = bcd_adjust(bcd_q);
    if (start) begin
      bcd_d    = {BCD_W{1'b0}};
      mag_d    = bin;
      cnt_d    = {CNT_W{1'b0}};
      active_d = 1'b1;
    end else if (active_q) begin
      // {bcd, mag} shifted left by one after the add-3 correction
      bcd_d = {bcd_adj_s[BCD_W-2:0], mag_q[WIDTH-1]};
      mag_d = {mag_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        active_d = 1'b0;
      end else begin
        active_d = 1'b1;
      end
    end else begin
      active_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_q    <= {BCD_W{1'b0}};
      mag_q    <= {WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      active_q <= 1'b0;
    end else begin
      bcd_q    <= bcd_d;
      mag_q    <= mag_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign bcd  = bcd_q;
  assign done = active_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/signed_result_display.sv
// signed_result_display
// Latches a signed product on in_valid, converts its magnitude to BCD with a
// sequential double-dabble and drives a 4-digit multiplexed 7-segment display
// plus a sign LED. Magnitudes above 9999 show a dash on every digit.
// Optional build macro LEADING_ZERO_BLANK_EN: blanks leading zero digits
// (units digit always shown, dash pattern unaffected).
// Ports:
//   clk, reset         : 27 MHz clock, synchronous active-high reset
//   in_valid/in_result : single-cycle strobe and signed WIDTH-bit product
//   busy               : high during LOAD, SHIFT and DONE
//   conv_done          : one-cycle pulse when new digits are latched
//   overflow           : last latched magnitude exceeds 9999
//   u_display_sign     : last latched result is negative
//   u_display_segments : active-low segments, bit0=a .. bit6=g
//   u_display_select   : active-low one-hot digit enable, bit0 = units
module signed_result_display
  import display_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int REFRESH_DIV = 27000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_result,
  output logic             busy,
  output logic             conv_done,
  output logic             overflow,
  output logic             u_display_sign,
  output logic [6:0]       u_display_segments,
  output logic [3:0]       u_display_select
);

  localparam int RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_DIV - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              sign_q, sign_d;
  logic [DISP_W-1:0] digits_q, digits_d;
  logic              overflow_q, overflow_d;
  logic              disp_sign_q, disp_sign_d;
  logic              busy_q, busy_d;
  logic              conv_done_q, conv_done_d;
  logic [RC_W-1:0]   ref_cnt_q, ref_cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        sel_q, sel_d;
  logic [6:0]        seg_q, seg_d;

  logic              conv_start_s;
  logic [WIDTH-1:0]  load_mag_s;
  logic [BCD_W-1:0]  bcd_s;
  logic              conv_last_s;
  logic [3:0]        nib_s;
`ifdef LEADING_ZERO_BLANK_EN
  logic              lead_zero_s;
`endif

  bin2bcd_seq #(.WIDTH(WIDTH)) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start_s),
    .bin   (load_mag_s),
    .bcd   (bcd_s),
    .done  (conv_last_s)
  );

  // Magnitude of the captured result; -2^(WIDTH-1) maps onto 2^(WIDTH-1) unsigned.
  always_comb begin
    if (result_q[WIDTH-1]) begin
      load_mag_s = ~result_q + WIDTH'(1);
    end else begin
      load_mag_s = result_q;
    end
  end

  // Conversion FSM: next state, capture and latching of the displayed result.
  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    sign_d       = sign_q;
    digits_d     = digits_q;
    overflow_d   = overflow_q;
    disp_sign_d  = disp_sign_q;
    conv_start_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          result_d = in_result;
          state_d  = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        sign_d       = result_q[WIDTH-1];
        conv_start_s = 1'b1;
        state_d      = SHIFT;
      end
      SHIFT: begin
        if (conv_last_s) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        digits_d    = bcd_s[DISP_W-1:0];
        // Magnitude never reaches 100000, so a non-zero ten-thousands digit
        // is exactly the "above 9999" condition.
        overflow_d  = (bcd_s[BCD_W-1:DISP_W] != 4'd0);
        disp_sign_d = sign_q && (bcd_s != {BCD_W{1'b0}});
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d      = (state_d != IDLE);
    conv_done_d = (state_d == DONE);
  end

  // Scan: refresh divider, digit index and the segment/select pattern derived
  // from the same next index and next digits so both change together.
  always_comb begin
    if (ref_cnt_q == RC_LAST) begin
      ref_cnt_d = {RC_W{1'b0}};
      idx_d     = idx_q + 2'd1;
    end else begin
      ref_cnt_d = ref_cnt_q + RC_W'(1);
      idx_d     = idx_q;
    end
    nib_s = digits_d[{idx_d, 2'b00} +: 4];
    sel_d = ~(4'b0001 << idx_d);
`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every higher digit are zero.
    case (idx_d)
      2'd3:    lead_zero_s = (digits_d[15:12] == 4'd0);
      2'd2:    lead_zero_s = (digits_d[15:8] == 8'd0);
      2'd1:    lead_zero_s = (digits_d[15:4] == 12'd0);
      default: lead_zero_s = 1'b0;
    endcase
    if (overflow_d) begin
      seg_d = SEG_DASH;
    end else if (lead_zero_s) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = seg_decode(nib_s);
    end
`else
    if (overflow_d) begin
      seg_d = SEG_DASH;
    end else begin
      seg_d = seg_decode(nib_s);
    end
`endif
  end

  // All state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      result_q    <= {WIDTH{1'b0}};
      sign_q      <= 1'b0;
      digits_q    <= {DISP_W{1'b0}};
      overflow_q  <= 1'b0;
      disp_sign_q <= 1'b0;
      busy_q      <= 1'b0;
      conv_done_q <= 1'b0;
      ref_cnt_q   <= {RC_W{1'b0}};
      idx_q       <= 2'd0;
      sel_q       <= 4'b1110;
      seg_q       <= SEG_DIGIT[0];
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      sign_q      <= sign_d;
      digits_q    <= digits_d;
      overflow_q  <= overflow_d;
      disp_sign_q <= disp_sign_d;
      busy_q      <= busy_d;
      conv_done_q <= conv_done_d;
      ref_cnt_q   <= ref_cnt_d;
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
    end
  end

  assign busy               = busy_q;
  assign conv_done          = conv_done_q;
  assign overflow           = overflow_q;
  assign u_display_sign     = disp_sign_q;
  assign u_display_segments = seg_q;
  assign u_display_select   = sel_q;

endmodule

// File: tb/tb_signed_result_display.sv
// Testbench for signed_result_display (REFRESH_DIV = 4).
// Stimulus pushes each accepted value into a scoreboard queue; a monitor on the
// falling edge checks conv_done timing, busy, sign, overflow and the scanned
// select/segment outputs against an arithmetic model of the displayed value.
module tb_signed_result_display;

  localparam int W  = 16;
  localparam int RD = 4;

  localparam logic [6:0] SEG_TAB [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_result;
  logic         busy, conv_done, overflow, u_display_sign;
  logic [6:0]   u_display_segments;
  logic [3:0]   u_display_select;

  typedef struct {
    logic [W-1:0] val;
    int           issue;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   ticks    = 0;
  bit   armed    = 1'b0;
  int   disp_mag = 0;
  bit   disp_neg = 1'b0;

  signed_result_display #(.WIDTH(W), .REFRESH_DIV(RD)) dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_result          (in_result),
    .busy               (busy),
    .conv_done          (conv_done),
    .overflow           (overflow),
    .u_display_sign     (u_display_sign),
    .u_display_segments (u_display_segments),
    .u_display_select   (u_display_select)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Cycle counter and cycles elapsed since the last reset edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      ticks <= 0;
      armed <= 1'b1;
    end else begin
      ticks <= ticks + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int mag_of(input logic [W-1:0] v);
    int s;
    s = int'($signed(v));
    return (s < 0) ? -s : s;
  endfunction

  function automatic logic [6:0] exp_seg(input int mag, input int pos);
    int p10;
    p10 = 1;
    for (int i = 0; i < pos; i++) p10 = p10 * 10;
    if (mag > 9999) return 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
    if (pos > 0 && mag < p10) return 7'b1111111;
`endif
    return SEG_TAB[(mag / p10) % 10];
  endfunction

  // Monitor: compares outputs with the model and retires scoreboard entries.
  always @(negedge clk) begin
    int       pos;
    logic [3:0] exp_sel;
    bit       exp_busy;
    exp_t     e;
    if (reset) begin
      disp_mag = 0;
      disp_neg = 1'b0;
    end else if (armed) begin
      pos     = (ticks / RD) % 4;
      exp_sel = ~(4'b0001 << pos);
      check("select", int'(u_display_select), int'(exp_sel));
      check("segments", int'(u_display_segments), int'(exp_seg(disp_mag, pos)));
      check("overflow", int'(overflow), int'(disp_mag > 9999));
      check("sign", int'(u_display_sign), int'(disp_neg));
      exp_busy = (sb_q.size() > 0) && (cyc >= sb_q[0].issue + 1);
      check("busy", int'(busy), int'(exp_busy));
      if (conv_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_conv_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("conv_done_latency", cyc - e.issue, 18);
          disp_mag = mag_of(e.val);
          disp_neg = (int'($signed(e.val)) < 0);
        end
      end else if (sb_q.size() > 0 && cyc > sb_q[0].issue + 18) begin
        check("conv_done_missing", 0, 1);
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic issue(input logic [W-1:0] v);
    exp_t e;
    e.val   = v;
    e.issue = cyc;
    sb_q.push_back(e);
    in_valid  = 1'b1;
    in_result = v;
    tick();
    in_valid  = 1'b0;
    in_result = W'($urandom);
  endtask

  // Pulse in_valid while a conversion is running; the model expects no effect.
  task automatic spurious(input logic [W-1:0] v);
    in_valid  = 1'b1;
    in_result = v;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_wait: got pending %0d expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  function automatic logic [W-1:0] rand_val();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0: v = W'($urandom);
      1: v = W'($urandom_range(0, 9999));
      2: begin
        case ($urandom_range(0, 5))
          0: v = 16'd9999;
          1: v = 16'd10000;
          2: v = 16'h8000;
          3: v = 16'h7FFF;
          4: v = 16'd0;
          default: v = 16'd1;
        endcase
      end
      default: v = W'($urandom_range(0, 99));
    endcase
    if ($urandom_range(0, 1) == 1) v = 16'd0 - v;
    return v;
  endfunction

  logic [W-1:0] directed [0:9] = '{
    16'hFFD6, 16'd9999, 16'd10000, 16'h8000, 16'd16384,
    16'd0, 16'hFFFF, 16'd1, 16'hD8F1, 16'h7FFF
  };

  initial begin
    logic [W-1:0] v;
    int           off;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_result = 16'd0;
    hold(3);
    reset = 1'b0;
    hold(20);

    foreach (directed[i]) begin
      issue(directed[i]);
      wait_idle();
      hold(18);
    end

    // Second strobe five cycles into a conversion must be ignored.
    issue(16'd777);
    hold(4);
    spurious(16'd123);
    wait_idle();
    hold(18);

    // Reset in the middle of the shift phase.
    issue(16'hFB2E);
    hold(9);
    reset = 1'b1;
    sb_q.delete();
    tick();
    reset = 1'b0;
    hold(24);

    for (int k = 0; k < 30; k++) begin
      v = rand_val();
      issue(v);
      if ($urandom_range(0, 2) == 0) begin
        off = $urandom_range(1, 17);
        hold(off - 1);
        spurious(W'($urandom));
      end
      wait_idle();
      hold($urandom_range(0, 20));
    end

    hold(20);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_result_display.md
Name: signed_result_display

Overview:
- Downstream consumer of the signed multiplier result.
- Latches a 16-bit two's-complement product on a valid pulse and converts its magnitude to BCD with a sequential double-dabble.
- Drives a 4-digit multiplexed 7-segment display plus a separate sign LED.
- Sits between the multiplier core and the board display pins inside top.

Parameters:
- WIDTH, 16, width of the signed input product.
- REFRESH_DIV, 27000, clk cycles each digit stays selected (1 ms at 27 MHz).

Ports:
- clk  input  1  system clock, 27 MHz.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  single-cycle strobe, in_result is valid.
- in_result  input  WIDTH  signed product from the multiplier.
- busy  output  1  high while a conversion is in progress.
- conv_done  output  1  one-cycle pulse when new digits are latched.
- overflow  output  1  magnitude of the last latched result exceeds 9999.
- u_display_sign  output  1  high when the last latched result is negative.
- u_display_segments  output  7  active-low segments, bit0=a … bit6=g.
- u_display_select  output  4  active-low one-hot digit enable, bit0 = units.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). No asynchronous reset anywhere.
- Reset values:
  - State is IDLE; busy=0, conv_done=0, overflow=0, u_display_sign=0.
  - Digit register is 0000; scan index is 0; refresh counter is 0.
  - u_display_select=4'b1110, u_display_segments=7'b1000000 (shows '0').
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE: when in_valid=1, capture in_result and go to LOAD. busy rises the next cycle.
- in_valid while not in IDLE is ignored; no queueing.
- LOAD:
  - sign = in_result[WIDTH-1].
  - magnitude = sign ? -in_result : in_result, as unsigned WIDTH bits. -32768 gives 32768, so there is no extra bit.
  - Clear the 20-bit BCD accumulator and the shift counter.
- SHIFT: exactly WIDTH cycles. Each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, mag} left by 1.
- DONE:
  - Latch the low 4 BCD digits into the display register.
  - overflow = (magnitude > 9999); u_display_sign = sign && magnitude != 0.
  - conv_done=1 for this cycle only; next state IDLE.
- Latency: in_valid sampled at cycle t gives LOAD at t+1, SHIFT at t+2..t+17, DONE at t+18. New outputs are visible from t+19.
- busy is high during LOAD, SHIFT and DONE.
- Previous digits stay displayed until DONE.
- Overflow display: all four digits show a dash, 7'b0111111. Sign LED still reflects the sign.
- Scan:
  - The refresh counter wraps at REFRESH_DIV-1. On wrap, the scan index increments modulo 4 (3 wraps to 0).
  - Select and segments are registered from the same index, so they change together with no ghosting cycle.
- Digit decode: 0-9 use standard active-low patterns. Nibble codes 10-15 are unreachable and decode to blank (7'b1111111).
- Reset mid-conversion: returns to IDLE, clears the digit register, and shows 0000 immediately.
- Scan continues independently of the FSM.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: the displayed digit is blank (7'b1111111) when it and all more-significant digits are 0. The units digit is never blanked. Does not apply to the overflow dash pattern.
- Undefined: all four digits are always shown with leading zeros (e.g. 0042).

Decomposition:
- Package display_pkg holds:
  - state_t enum {IDLE, LOAD, SHIFT, DONE}.
  - SEG_DIGIT[0:9] active-low pattern array, SEG_BLANK, SEG_DASH.
  - BCD_DIGITS=5, DISP_DIGITS=4, DISP_MAX=9999.
- Sub-module bin2bcd_seq: the double-dabble datapath plus its shift counter, with start/done handshake.
- signed_result_display owns the FSM, sign/magnitude logic, latching, scan counter and segment decode.

Test Plan:
- Reset: after reset → select=1110, segments=1000000, busy=0, overflow=0, sign=0.
- Negative result: in_result=-42 (16'hFFD6) pulse → conv_done exactly 18 cycles later; digits 0,0,4,2; u_display_sign=1; overflow=0. With LEADING_ZERO_BLANK_EN, digits 3-2 blank.
- Boundaries:
  - 9999 → 9999 shown, overflow=0.
  - 10000 → overflow=1, all digits show the dash pattern.
  - -32768 → overflow=1, sign=1.
  - -128×-128 = 16384 → overflow=1, sign=0.
- Ignored input: in_valid asserted again 5 cycles into a conversion with 123 → ignored; the first value is displayed; busy stays continuous.
- Scan timing: REFRESH_DIV=4 in the bench → select cycles 1110→1101→1011→0111→1110 every 4 clocks. Segments match each digit in the same cycle.
- Reset mid-SHIFT: reset asserted at cycle t+10 → next cycle is IDLE, busy=0, display shows 0000, no conv_done pulse.
